// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a boot image into instruction memory, holds the CPU in reset, then serves fetches.
// Optional `IMEM_ZERO_FILL_EN: zero the unloaded tail of memory before releasing the CPU.
module imem_boot_loader #(
  parameter int DBITS = 32,
  parameter int IMEM_ADDR_BIT_WIDTH = 11,
  parameter logic [31:0] START_PC = 32'h40,
  parameter int HOLD_CYCLES = 16
) (
  input  logic CLOCK_50,
  input  logic FPGA_RESET,
  input  logic ld_valid,
  input  logic [DBITS-1:0] ld_data,
  input  logic ld_last,
  output logic ld_ready,
  input  logic [DBITS-1:0] pcOut,
  output logic [DBITS-1:0] instWord,
  output logic cpu_reset,
  output logic fetch_err,
  output logic ld_err,
  output logic [IMEM_ADDR_BIT_WIDTH:0] words_loaded
);
  localparam int AW = IMEM_ADDR_BIT_WIDTH;
  typedef enum logic [2:0] {IDLE, LOAD, FILL, HOLD, RUN} state_t;
`ifdef IMEM_ZERO_FILL_EN
  localparam state_t LOADED = FILL;
`else
  localparam state_t LOADED = HOLD;
`endif
  state_t state, nxt;
  logic [DBITS-1:0] mem [2**AW];
  logic [7:0] hcnt;
  logic [DBITS-1:0] idx;
  logic xfer, bad;
  assign xfer = ld_valid && ld_ready;
  assign idx = (pcOut - DBITS'(START_PC)) >> 2;
  assign bad = pcOut < DBITS'(START_PC) || pcOut[1:0] != 2'b00 || |idx[DBITS-1:AW];
`ifdef IMEM_ZERO_FILL_EN
  // fill_a walks from the first unloaded word up to the top of memory
  logic [AW:0] fill_off, fill_a;
  logic fill_done;
  assign fill_a = words_loaded + fill_off;
  assign fill_done = fill_a[AW] || &fill_a[AW-1:0];
  always_ff @(posedge CLOCK_50 or posedge FPGA_RESET)
    if (FPGA_RESET) fill_off <= '0;
    else fill_off <= (state == FILL) ? fill_off + (AW+1)'(1) : '0;
`endif
  always_ff @(posedge CLOCK_50 or posedge FPGA_RESET)
    if (FPGA_RESET) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = LOAD;
      LOAD: nxt = (xfer && ld_last) ? LOADED : LOAD;
`ifdef IMEM_ZERO_FILL_EN
      FILL: nxt = fill_done ? HOLD : FILL;
`endif
      HOLD: nxt = (hcnt == 8'(HOLD_CYCLES - 1)) ? RUN : HOLD;
      default: nxt = state;
    endcase
  end
  always_comb begin
    ld_ready = state == LOAD;
    cpu_reset = state != RUN;
  end
  // words_loaded[AW] set means memory is full; it never advances past depth
  always_ff @(posedge CLOCK_50 or posedge FPGA_RESET) begin
    if (FPGA_RESET) begin
      hcnt <= '0;
      instWord <= '0;
      fetch_err <= 1'b0;
      ld_err <= 1'b0;
      words_loaded <= '0;
    end else begin
      hcnt <= (state == HOLD) ? hcnt + 8'd1 : 8'd0;
      instWord <= (state == RUN && !bad) ? mem[idx[AW-1:0]] : '0;
      if (state == RUN && bad) fetch_err <= 1'b1;
      if (xfer && words_loaded[AW]) ld_err <= 1'b1;
      if (xfer && !words_loaded[AW]) words_loaded <= words_loaded + (AW+1)'(1);
    end
  end
  always_ff @(posedge CLOCK_50) begin
    if (xfer && !words_loaded[AW]) mem[words_loaded[AW-1:0]] <= ld_data;
`ifdef IMEM_ZERO_FILL_EN
    else if (state == FILL && !fill_a[AW]) mem[fill_a[AW-1:0]] <= '0;
`endif
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: drives a full-size and a 4-word loader with the same stream and
// checks both against a phase-level model every cycle, plus hand-computed expectations.
module tb_imem_boot_loader;
  localparam logic [31:0] START = 32'h40;
  localparam int HOLD = 16;
  localparam int P_IDLE = 0, P_LOAD = 1, P_FILL = 2, P_HOLD = 3, P_RUN = 4;
`ifdef IMEM_ZERO_FILL_EN
  localparam bit FILL_EN = 1;
`else
  localparam bit FILL_EN = 0;
`endif
  logic clk = 0, rst = 1, vld = 0, lst = 0;
  logic [31:0] data = 0, pc = 32'h40;
  logic rdy0, crst0, fe0, le0, rdy1, crst1, fe1, le1;
  logic [31:0] iw0, iw1;
  logic [11:0] wl0;
  logic [2:0] wl1;
  int n_tests = 0, n_fail = 0;
  logic [31:0] mm [2][2048];
  int ph [2], mwl [2], hc [2], fl [2];
  bit mle [2], mfe [2];
  bit [31:0] mi [2];
  int dep [2] = '{2048, 4};

  always #5 clk = ~clk;

  imem_boot_loader u0 (
    .CLOCK_50(clk), .FPGA_RESET(rst), .ld_valid(vld), .ld_data(data), .ld_last(lst),
    .ld_ready(rdy0), .pcOut(pc), .instWord(iw0), .cpu_reset(crst0), .fetch_err(fe0),
    .ld_err(le0), .words_loaded(wl0)
  );
  imem_boot_loader #(.IMEM_ADDR_BIT_WIDTH(2)) u1 (
    .CLOCK_50(clk), .FPGA_RESET(rst), .ld_valid(vld), .ld_data(data), .ld_last(lst),
    .ld_ready(rdy1), .pcOut(pc), .instWord(iw1), .cpu_reset(crst1), .fetch_err(fe1),
    .ld_err(le1), .words_loaded(wl1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] wv(input int i);
    return i == 0 ? 32'h2f000000 : i == 1 ? 32'hfbf00001 : 32'h12340000 + 32'(i);
  endfunction

  task automatic model_step(input int k);
    logic [31:0] off;
    if (rst) begin
      ph[k] = P_IDLE; mwl[k] = 0; mle[k] = 0; mfe[k] = 0; mi[k] = 0; hc[k] = 0;
      return;
    end
    off = (pc - START) >> 2;
    if (ph[k] == P_RUN && (pc < START || pc[1:0] != 2'b00 || off >= 32'(dep[k]))) begin
      mi[k] = 0;
      mfe[k] = 1;
    end else mi[k] = (ph[k] == P_RUN) ? mm[k][off] : 0;
    case (ph[k])
      P_IDLE: ph[k] = P_LOAD;
      P_LOAD: if (vld) begin
        if (mwl[k] < dep[k]) begin mm[k][mwl[k]] = data; mwl[k]++; end
        else mle[k] = 1;
        if (lst) begin
          if (FILL_EN) begin
            for (int a = mwl[k]; a < dep[k]; a++) mm[k][a] = 0;
            fl[k] = (mwl[k] < dep[k]) ? dep[k] - mwl[k] : 1;
            ph[k] = P_FILL;
          end else begin
            ph[k] = P_HOLD;
            hc[k] = 0;
          end
        end
      end
      P_FILL: begin
        fl[k]--;
        if (fl[k] == 0) begin ph[k] = P_HOLD; hc[k] = 0; end
      end
      P_HOLD: begin
        hc[k]++;
        if (hc[k] == HOLD) ph[k] = P_RUN;
      end
      default: ;
    endcase
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step(0);
    model_step(1);
  end

  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk(k ? "ready1" : "ready0", k ? rdy1 : rdy0, 32'(ph[k] == P_LOAD));
      chk(k ? "cpu_reset1" : "cpu_reset0", k ? crst1 : crst0, 32'(ph[k] != P_RUN));
      chk(k ? "inst1" : "inst0", k ? iw1 : iw0, mi[k]);
      chk(k ? "fetch_err1" : "fetch_err0", k ? fe1 : fe0, 32'(mfe[k]));
      chk(k ? "ld_err1" : "ld_err0", k ? le1 : le0, 32'(mle[k]));
      chk(k ? "words1" : "words0", k ? 32'(wl1) : 32'(wl0), 32'(mwl[k]));
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic l, input int gap);
    repeat (gap) begin vld = 0; lst = 1; data = $urandom; tick(); end
    vld = 1; data = d; lst = l;
    tick();
    vld = 0; lst = 0;
  endtask

  task automatic fetch(input logic [31:0] a);
    pc = a;
    tick();
  endtask

  initial begin
    int cnt;
    repeat (2) tick();
    chk("rst_words", wl0, 0);
    chk("rst_cpu_reset", crst0, 1);
    chk("rst_ready", rdy0, 0);
    chk("rst_inst", iw0, 0);
    rst = 0;
    tick();
    chk("load_ready", rdy0, 1);
    for (int i = 0; i < 10; i++) send(wv(i), i == 9, i % 3);
    cnt = 0;
    while (crst0 && cnt < 5000) begin cnt++; tick(); end
    chk("hold_cycles", cnt, HOLD + (FILL_EN ? 2048 - 10 : 0));
    chk("words_10", wl0, 10);
    chk("no_ld_err", le0, 0);
    chk("small_words", wl1, 4);
    chk("small_ld_err", le1, 1);
    fetch(32'h40); chk("f40", iw0, 32'h2f000000);
    fetch(32'h44); chk("f44", iw0, 32'hfbf00001);
    chk("f44_ok", fe0, 0);
    fetch(32'h50); chk("f50_big", iw0, 32'h12340004);
    chk("f50_small", iw1, 0);
    chk("f50_small_err", fe1, 1);
    fetch(32'h3c); chk("f3c", iw0, 0);
    chk("f3c_err", fe0, 1);
    fetch(32'h42); chk("f42", iw0, 0);
    chk("f42_err", fe0, 1);
    fetch(32'h40); chk("f40_again", iw0, 32'h2f000000);
    chk("err_sticky", fe0, 1);
    rst = 1; tick(); rst = 0; tick();
    send(32'h55555555, 0, 0);
    chk("words_before_rst", wl0, 1);
    #2 rst = 1;
    #1;
    chk("midrst_words", wl0, 0);
    chk("midrst_ready", rdy0, 0);
    chk("midrst_cpu_reset", crst0, 1);
    tick(); rst = 0; tick();
    send(32'haaaa0000, 0, 1);
    send(32'haaaa0001, 1, 0);
    cnt = 0;
    while (crst0 && cnt < 5000) begin cnt++; tick(); end
    chk("run_reached", crst0, 0);
    fetch(32'h48); chk("f48_tail", iw0, FILL_EN ? 32'h0 : 32'h12340002);
    fetch(32'h40); chk("reload_w0", iw0, 32'haaaa0000);
    fetch(32'h44); chk("reload_w1", iw0, 32'haaaa0001);
    chk("reload_words", wl0, 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_boot_loader.md
IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

Interface
REQ-001 SHALL have parameter DBITS, default 32, instruction word width.
REQ-002 SHALL have parameter IMEM_ADDR_BIT_WIDTH, default 11, word-address width; depth = 2**IMEM_ADDR_BIT_WIDTH.
REQ-003 SHALL have parameter START_PC, default 32'h40, byte address of word 0.
REQ-004 SHALL have parameter HOLD_CYCLES, default 16, processor-reset hold after load (1..255).
REQ-005 SHALL have port CLOCK_50, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port FPGA_RESET, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port ld_valid, input, 1, load word present.
REQ-008 SHALL have port ld_data, input, DBITS, load word.
REQ-009 SHALL have port ld_last, input, 1, marks final load word.
REQ-010 SHALL have port ld_ready, output, 1, loader accepts word.
REQ-011 SHALL have port pcOut, input, DBITS, processor fetch byte address.
REQ-012 SHALL have port instWord, output, DBITS, fetched instruction.
REQ-013 SHALL have ports cpu_reset (output, 1, processor reset, active-high), fetch_err (output, 1, sticky bad-fetch flag), ld_err (output, 1, sticky overflow flag), words_loaded (output, IMEM_ADDR_BIT_WIDTH+1, count of accepted words).

Function
REQ-014 SHALL implement states IDLE, LOAD, FILL, HOLD, RUN.
REQ-015 SHALL leave IDLE for LOAD on the first cycle after reset deassertion.
REQ-016 SHALL drive ld_ready=1 only in LOAD; transfer occurs when ld_valid and ld_ready are both 1 on a rising edge.
REQ-017 SHALL write each transferred word at word index words_loaded, then increment words_loaded.
REQ-018 SHALL, on a transfer with ld_last=1, go to FILL (macro defined) or HOLD (macro undefined) on the next cycle.
REQ-019 SHALL, on a transfer when words_loaded equals depth, drop the word, set ld_err, and still honour ld_last.
REQ-020 SHALL in HOLD count HOLD_CYCLES cycles with cpu_reset=1, then enter RUN.
REQ-021 SHALL hold cpu_reset=1 in every state except RUN, 0 in RUN.
REQ-022 SHALL in RUN compute index = (pcOut - START_PC) >> 2 and register instWord = mem[index] one cycle later (latency 1).
REQ-023 SHALL, when pcOut < START_PC, pcOut[1:0] != 0, or index >= depth, register instWord = 0 and set fetch_err.
REQ-024 SHALL drive instWord = 0 outside RUN and ignore pcOut there.
REQ-025 SHALL stay in RUN until reset; ld_valid in RUN/HOLD/FILL is ignored and ld_ready stays 0.
REQ-026 SHALL treat words_loaded saturating at depth; no wrap to 0.

Reset
REQ-027 SHALL on FPGA_RESET=1 asynchronously force state IDLE, cpu_reset=1, ld_ready=0, instWord=0, fetch_err=0, ld_err=0, words_loaded=0, HOLD counter 0.
REQ-028 SHALL not clear memory contents on reset; reset mid-LOAD restarts loading at index 0.

Configuration
REQ-029 SHALL, with macro IMEM_ZERO_FILL_EN defined, in FILL write 0 to every index from words_loaded to depth-1, one word per cycle, then enter HOLD.
REQ-030 SHALL, without IMEM_ZERO_FILL_EN, omit FILL entirely; unloaded words keep prior contents.

Verification
REQ-031 SHALL cover: reset, load 10 words (32'h2f000000, 32'hfbf00001, ...) last on 10th -> words_loaded=10, cpu_reset=1 for 16 cycles after HOLD entry, then 0.
REQ-032 SHALL cover: RUN, pcOut=32'h40 then 32'h44 -> instWord=32'h2f000000 then 32'hfbf00001, each one cycle after pcOut.
REQ-033 SHALL cover: RUN, pcOut=32'h3c and 32'h42 -> instWord=0, fetch_err=1 and stays 1.
REQ-034 SHALL cover: IMEM_ADDR_BIT_WIDTH=2, load 5 words -> ld_err=1, words_loaded=4, fetch of 32'h50 returns 0 with fetch_err=1.
REQ-035 SHALL cover: ld_valid toggling with gaps during LOAD -> only handshaked words written, order preserved.
REQ-036 SHALL cover: IMEM_ZERO_FILL_EN defined, memory preloaded nonzero, load 2 words -> fetch of 32'h48 returns 0; undefined -> returns preloaded value; reset asserted mid-LOAD -> state IDLE, words_loaded=0 immediately.
